// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch sequencer: unlocked tag, funct3 branch codes,
// FSM state encoding and default-width word/address/tag types.
package branch_ctrl_pkg;

   localparam int TAG_W_DEF = 4;
   localparam int XLEN_DEF  = 32;

   typedef logic [XLEN_DEF-1:0]  addr_t;
   typedef logic [XLEN_DEF-1:0]  word_t;
   typedef logic [TAG_W_DEF-1:0] regtag_t;

   localparam regtag_t UNLOCKED = '0;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_EXEC,
      ST_REDIRECT,
      ST_RELEASE
   } state_t;

endpackage

// File: rtl/branch_ctrl_cmp.sv
// Combinational branch condition evaluator: funct3 plus operands -> taken / illegal.
module branch_cmp
   import branch_ctrl_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] x,
   input  logic [XLEN-1:0] y,
   output logic            taken,
   output logic            illegal
);

   logic signed [XLEN-1:0] xs;
   logic signed [XLEN-1:0] ys;

   assign xs = x;
   assign ys = y;

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (op)
         F3_BEQ:  taken = (x == y);
         F3_BNE:  taken = (x != y);
         F3_BLT:  taken = (xs < ys);
         F3_BGE:  taken = (xs >= ys);
         F3_BLTU: taken = (x < y);
         F3_BGEU: taken = (x >= y);
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// Branch station sequencer: waits for operands, evaluates, redirects fetch on taken.
// Optional BRANCH_STATS_EN adds executed/taken branch counters.
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int TAG_W = 4,
   parameter int XLEN  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             rs_busy,
   input  logic [XLEN-1:0]  rs_pc,
   input  logic [XLEN-1:0]  rs_offset,
   input  logic [2:0]       rs_op,
   input  logic [TAG_W-1:0] rs_tagx,
   input  logic [TAG_W-1:0] rs_tagy,
   input  logic [XLEN-1:0]  rs_datax,
   input  logic [XLEN-1:0]  rs_datay,
   output logic             busy_branch,
   output logic             alloc_stall,
   output logic             jump_en,
   output logic [XLEN-1:0]  jump_pc,
   input  logic             fetch_ack,
   output logic             flush,
   output logic             bad_op
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]      stat_branches,
   output logic [31:0]      stat_taken
`endif
);

   state_t          state;
   logic [XLEN-1:0] x_q;
   logic [XLEN-1:0] y_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] off_q;
   logic [2:0]      op_q;
   logic            taken;
   logic            illegal;
   logic            ops_ready;
   logic [XLEN-1:0] target;

   assign ops_ready = (rs_tagx == TAG_W'(UNLOCKED)) && (rs_tagy == TAG_W'(UNLOCKED));
   assign target    = pc_q + off_q;

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .op      (op_q),
      .x       (x_q),
      .y       (y_q),
      .taken   (taken),
      .illegal (illegal)
   );

   // In IDLE the station's own occupancy is echoed back so a fresh entry stays held.
   assign busy_branch = (state == ST_IDLE) ? rs_busy : (state != ST_RELEASE);
   assign alloc_stall = (state == ST_WAIT) || (state == ST_EXEC) || (state == ST_REDIRECT);

   always_ff @(posedge clk) begin
      if (rdy && state == ST_WAIT && ops_ready) begin
         x_q   <= rs_datax;
         y_q   <= rs_datay;
         pc_q  <= rs_pc;
         off_q <= rs_offset;
         op_q  <= rs_op;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         jump_en <= 1'b0;
         jump_pc <= '0;
         flush   <= 1'b0;
         bad_op  <= 1'b0;
`ifdef BRANCH_STATS_EN
         stat_branches <= '0;
         stat_taken    <= '0;
`endif
      end else if (rdy) begin
         flush <= 1'b0;
         case (state)
            ST_IDLE: if (rs_busy) state <= ST_WAIT;
            ST_WAIT: if (ops_ready) state <= ST_EXEC;
            ST_EXEC: begin
`ifdef BRANCH_STATS_EN
               stat_branches <= stat_branches + 32'd1;
               if (taken) stat_taken <= stat_taken + 32'd1;
`endif
               if (illegal) bad_op <= 1'b1;
               if (taken) begin
                  state   <= ST_REDIRECT;
                  jump_en <= 1'b1;
                  jump_pc <= target;
               end else begin
                  state <= ST_RELEASE;
               end
            end
            ST_REDIRECT: begin
               if (fetch_ack) begin
                  jump_en <= 1'b0;
                  flush   <= 1'b1;
                  state   <= ST_RELEASE;
               end
            end
            ST_RELEASE: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: directed branches push expected redirect/release
// events; a negedge monitor pops and compares as the DUT presents them.
module tb_branch_ctrl;

   logic        clk = 1'b0;
   logic        rst, rdy, rs_busy, fetch_ack;
   logic [31:0] rs_pc, rs_offset, rs_datax, rs_datay;
   logic [2:0]  rs_op;
   logic [3:0]  rs_tagx, rs_tagy;
   logic        busy_branch, alloc_stall, jump_en, flush, bad_op;
   logic [31:0] jump_pc;
`ifdef BRANCH_STATS_EN
   logic [31:0] stat_branches, stat_taken;
`endif

   int n_total = 0;
   int n_bad   = 0;

   typedef struct packed {
      logic        redir;
      logic [31:0] pc;
      logic        fl;
      logic        bad;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   branch_ctrl #(.TAG_W(4), .XLEN(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rs_busy(rs_busy),
      .rs_pc(rs_pc), .rs_offset(rs_offset), .rs_op(rs_op),
      .rs_tagx(rs_tagx), .rs_tagy(rs_tagy),
      .rs_datax(rs_datax), .rs_datay(rs_datay),
      .busy_branch(busy_branch), .alloc_stall(alloc_stall),
      .jump_en(jump_en), .jump_pc(jump_pc), .fetch_ack(fetch_ack),
      .flush(flush), .bad_op(bad_op)
`ifdef BRANCH_STATS_EN
      , .stat_branches(stat_branches), .stat_taken(stat_taken)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic sb_unexpected(input string nm);
      n_total++;
      n_bad++;
      $display("FAIL %s: got event want none", nm);
   endtask

   // Monitor: a jump_en rise is a redirect event, an alloc_stall fall is a release event.
   logic pj = 1'b0;
   logic pa = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (jump_en === 1'b1 && pj !== 1'b1) begin
         if (sb.size() == 0) sb_unexpected("sb_redir_unexp");
         else begin
            e = sb.pop_front();
            chk("sb_kind_redir", 32'(jump_en), 32'(e.redir));
            chk("sb_jump_pc", jump_pc, e.pc);
         end
      end
      if (pa === 1'b1 && alloc_stall === 1'b0) begin
         if (sb.size() == 0) sb_unexpected("sb_release_unexp");
         else begin
            e = sb.pop_front();
            chk("sb_kind_rel", 32'(jump_en), 32'(e.redir));
            chk("sb_flush", 32'(flush), 32'(e.fl));
            chk("sb_busy_rel", 32'(busy_branch), 32'd0);
            chk("sb_bad_op", 32'(bad_op), 32'(e.bad));
         end
      end
      pj = jump_en;
      pa = alloc_stall;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_br(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] pc, input logic [31:0] off,
                         input int lock, input int frz, input int ack_dly, input bit rst_mode,
                         input logic exp_taken, input logic [31:0] exp_pc, input logic exp_bad);
      exp_t e;
      if (exp_taken) begin
         e = '{redir: 1'b1, pc: exp_pc, fl: 1'b0, bad: 1'b0};
         sb.push_back(e);
      end
      e = '{redir: 1'b0, pc: 32'd0, fl: exp_taken && !rst_mode, bad: exp_bad};
      sb.push_back(e);

      rs_op = op; rs_datax = x; rs_datay = y; rs_pc = pc; rs_offset = off;
      rs_tagx = (lock > 0) ? 4'd3 : 4'd0;
      rs_tagy = 4'd0;
      rs_busy = 1'b1;
      step();
      rs_busy = 1'b0;
      chk("wait_stall", 32'(alloc_stall), 32'd1);
      chk("wait_busy", 32'(busy_branch), 32'd1);
      repeat (lock) begin
         chk("lock_stall", 32'(alloc_stall), 32'd1);
         chk("lock_nojump", 32'(jump_en), 32'd0);
         step();
      end
      rs_tagx = 4'd0;
      step();
      chk("exec_stall", 32'(alloc_stall), 32'd1);
      chk("exec_nojump", 32'(jump_en), 32'd0);
      step();
      if (exp_taken) begin
         chk("redir_jump_en", 32'(jump_en), 32'd1);
         chk("redir_pc", jump_pc, exp_pc);
         chk("redir_busy", 32'(busy_branch), 32'd1);
         if (rst_mode) begin
            rst = 1'b1;
            step();
            chk("rst_jump_en", 32'(jump_en), 32'd0);
            chk("rst_stall", 32'(alloc_stall), 32'd0);
            chk("rst_flush", 32'(flush), 32'd0);
            rst = 1'b0;
            step();
            chk("rst_flush2", 32'(flush), 32'd0);
            chk("rst_idle_jump", 32'(jump_en), 32'd0);
            return;
         end
         repeat (frz) begin
            rdy = 1'b0;
            fetch_ack = 1'b1;
            step();
            chk("frz_jump_en", 32'(jump_en), 32'd1);
            chk("frz_flush", 32'(flush), 32'd0);
            chk("frz_stall", 32'(alloc_stall), 32'd1);
         end
         rdy = 1'b1;
         fetch_ack = 1'b0;
         repeat (ack_dly) begin
            step();
            chk("hold_jump_en", 32'(jump_en), 32'd1);
            chk("hold_pc", jump_pc, exp_pc);
            chk("hold_flush", 32'(flush), 32'd0);
         end
         fetch_ack = 1'b1;
         step();
         fetch_ack = 1'b0;
         chk("rel_flush", 32'(flush), 32'd1);
         chk("rel_busy", 32'(busy_branch), 32'd0);
         chk("rel_jump_en", 32'(jump_en), 32'd0);
      end else begin
         chk("nt_jump_en", 32'(jump_en), 32'd0);
         chk("nt_busy", 32'(busy_branch), 32'd0);
         chk("nt_stall", 32'(alloc_stall), 32'd0);
         chk("nt_flush", 32'(flush), 32'd0);
      end
      step();
      chk("idle_flush", 32'(flush), 32'd0);
      chk("idle_busy", 32'(busy_branch), 32'd0);
      chk("idle_stall", 32'(alloc_stall), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; rs_busy = 1'b1; fetch_ack = 1'b0;
      rs_pc = '0; rs_offset = '0; rs_op = '0; rs_datax = '0; rs_datay = '0;
      rs_tagx = '0; rs_tagy = '0;
      step();
      step();
      chk("rst_alloc_stall", 32'(alloc_stall), 32'd0);
      chk("rst_jump_en0", 32'(jump_en), 32'd0);
      chk("rst_jump_pc", jump_pc, 32'd0);
      chk("rst_flush0", 32'(flush), 32'd0);
      chk("rst_bad_op", 32'(bad_op), 32'd0);
      chk("rst_busy_follow1", 32'(busy_branch), 32'd1);
      rs_busy = 1'b0;
      #1;
      chk("rst_busy_follow0", 32'(busy_branch), 32'd0);
      step();
      rst = 1'b0;
      step();

      // op, x, y, pc, off, lock, frz, ack_dly, rst_mode, taken, target, bad
      run_br(3'b000, 32'd5, 32'd5, 32'h1000, 32'd8, 0, 0, 2, 0, 1'b1, 32'h1008, 1'b0);
      run_br(3'b100, 32'hFFFFFFFF, 32'd1, 32'h2000, 32'hFFFFFFF0, 0, 0, 0, 0, 1'b1, 32'h1FF0, 1'b0);
      fetch_ack = 1'b1;
      run_br(3'b110, 32'hFFFFFFFF, 32'd1, 32'h2000, 32'hFFFFFFF0, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0);
      fetch_ack = 1'b0;
      run_br(3'b101, 32'd3, 32'hFFFFFFFE, 32'h3000, 32'h100, 4, 0, 1, 0, 1'b1, 32'h3100, 1'b0);
      run_br(3'b001, 32'd1, 32'd2, 32'hFFFFFFFC, 32'd8, 0, 0, 0, 0, 1'b1, 32'h00000004, 1'b0);
      run_br(3'b111, 32'd1, 32'hFFFFFFFF, 32'h5000, 32'd4, 0, 0, 0, 0, 1'b0, 32'h0, 1'b0);
      run_br(3'b000, 32'd7, 32'd7, 32'h4000, 32'h20, 0, 3, 0, 0, 1'b1, 32'h4020, 1'b0);
      run_br(3'b000, 32'd9, 32'd9, 32'h6000, 32'h40, 0, 0, 0, 1, 1'b1, 32'h6040, 1'b0);
      run_br(3'b010, 32'd0, 32'd0, 32'h7000, 32'h10, 0, 0, 0, 0, 1'b0, 32'h0, 1'b1);
      step();
      chk("bad_op_sticky", 32'(bad_op), 32'd1);
`ifdef BRANCH_STATS_EN
      chk("stat_branches", stat_branches, 32'd1);
      chk("stat_taken", stat_taken, 32'd0);
`endif
      step();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
